// File: rtl/iris_cmd_arbiter.sv
// iris_cmd_arbiter: round-robin share of one core command port, one command in flight.
// Optional IRIS_ARB_LOCK_EN adds req_lock to pin the grant for atomic sequences.
module iris_cmd_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 24,
  parameter  int ADDR_WIDTH = 16,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
`ifdef IRIS_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          core_valid,
  input  logic                          core_ready,
  output logic                          core_write,
  output logic [ADDR_WIDTH-1:0]         core_addr,
  output logic [DATA_WIDTH-1:0]         core_wdata,
  input  logic [DATA_WIDTH-1:0]         core_rdata,
  output logic                          busy
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    RESP
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    win;
  logic               found;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] lock_mask;
  logic               lock_q;

`ifdef IRIS_ARB_LOCK_EN
  logic            cmd_lock;
  logic [ID_W-1:0] lock_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q   <= 1'b0;
      cmd_lock <= 1'b0;
      lock_id  <= '0;
    end else begin
      if (state_q == IDLE && found)
        cmd_lock <= req_lock[win];
      if (state_q == WAIT_HI && core_ready) begin
        lock_q  <= cmd_lock;
        lock_id <= gnt_id;
      end
    end
  end

  assign lock_mask = lock_q ? (NUM_REQ'(1) << lock_id) : '1;
`else
  assign lock_q    = 1'b0;
  assign lock_mask = '1;
`endif

  assign elig = req_valid & lock_mask;
  assign busy = (state_q != IDLE);

  // Search starts just past the last winner and wraps.
  always_comb begin
    int k;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && elig[ID_W'(k)]) begin
        found = 1'b1;
        win   = ID_W'(k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && found)
      req_ready[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = ISSUE;
      ISSUE:   if (core_ready) state_d = WAIT_LO;
      WAIT_LO: if (!core_ready) state_d = WAIT_HI;
      WAIT_HI: if (core_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      gnt_id     <= '0;
      core_valid <= 1'b0;
      core_write <= 1'b0;
      core_addr  <= '0;
      core_wdata <= '0;
      rsp_valid  <= '0;
      rsp_id     <= '0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= '0;
      unique case (state_q)
        IDLE: begin
          if (found) begin
            core_valid <= 1'b1;
            core_write <= req_write[win];
            core_addr  <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
            core_wdata <= req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
            gnt_id     <= win;
            if (!lock_q)
              rr_ptr <= win;
          end
        end
        ISSUE: begin
          if (core_ready)
            core_valid <= 1'b0;
        end
        WAIT_HI: begin
          // Pulse is registered so it appears in the RESP cycle.
          if (core_ready) begin
            rsp_valid <= NUM_REQ'(1) << gnt_id;
            rsp_id    <= gnt_id;
            rsp_rdata <= core_write ? '0 : core_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iris_cmd_arbiter.sv
// tb_iris_cmd_arbiter: scoreboard bench with a behavioural core model.
// Build with IRIS_ARB_LOCK_EN to exercise the lock path.
module tb_iris_cmd_arbiter;

  localparam int N  = 4;
  localparam int DW = 24;
  localparam int AW = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
`ifdef IRIS_ARB_LOCK_EN
  logic [N-1:0]    req_lock = '0;
`endif
  logic [N-1:0]    rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_rdata;
  logic            core_valid;
  logic            core_ready = 1'b1;
  logic            core_write;
  logic [AW-1:0]   core_addr;
  logic [DW-1:0]   core_wdata;
  logic [DW-1:0]   core_rdata = '0;
  logic            busy;

  iris_cmd_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
`ifdef IRIS_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_rdata(rsp_rdata),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_write(core_write), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [DW-1:0] core_fn(input logic [AW-1:0] a);
    return 24'hABCDEF ^ {8'h00, a ^ 16'h0010};
  endfunction

  // Core model: idle ready=1; after a handshake ready drops for lat cycles.
  int            lat = 3;
  int            hold_off = 0;
  int            busy_cnt = 0;
  int            n_cmds = 0;
  int            stab_err = 0;
  int            hot_err = 0;
  logic          pend = 1'b0;
  logic          waiting = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic          cur_write = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [DW-1:0] w_wdata = '0;
  logic          w_write = 1'b0;

  always @(negedge clk) begin
    if (waiting && (core_valid !== 1'b1 || core_addr !== w_addr ||
        core_wdata !== w_wdata || core_write !== w_write))
      stab_err++;
    if (!$onehot0(req_ready)) hot_err++;
    if (!$onehot0(rsp_valid)) hot_err++;
    if (rst) begin
      core_ready = 1'b1;
      busy_cnt   = 0;
      pend       = 1'b0;
      waiting    = 1'b0;
    end else begin
      if (pend) begin
        busy_cnt   = lat;
        core_ready = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          core_ready = 1'b1;
          core_rdata = cur_write ? 24'h5A5A5A : core_fn(cur_addr);
        end
      end else if (hold_off > 0) begin
        core_ready = 1'b0;
        if (core_valid) hold_off--;
      end else begin
        core_ready = 1'b1;
      end
      pend = core_valid && core_ready;
      if (pend) begin
        cur_addr  = core_addr;
        cur_write = core_write;
        n_cmds++;
      end
      waiting = core_valid && !core_ready;
      w_addr  = core_addr;
      w_wdata = core_wdata;
      w_write = core_write;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();
  endtask

  task automatic send(input int id, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output bit ok);
    int n = 0;
    req_write[id] = w;
    req_addr[id*AW +: AW] = a;
    req_wdata[id*DW +: DW] = d;
    req_valid[id] = 1'b1;
    #1;
    while (req_ready[id] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    ok = (req_ready[id] === 1'b1);
    if (ok) exp_q.push_back('{id: IW'(id), rdata: w ? '0 : core_fn(a)});
    tick();
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    int n = 0;
    while (rsp_valid === '0 && n < 100) begin
      tick();
      n++;
    end
    ok = (rsp_valid !== '0);
  endtask

  task automatic pop_exp(output exp_t e, output bit had);
    had = (exp_q.size() != 0);
    e = had ? exp_q.pop_front() : '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    tick();
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL rst_req_ready got=%b want=0000", req_ready);
    end
    checks++;
    if ({core_valid, core_write, core_addr, core_wdata} !== '0) begin
      errors++;
      $display("FAIL rst_core got v=%b w=%b a=%h d=%h want all 0",
               core_valid, core_write, core_addr, core_wdata);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_rdata, busy} !== '0) begin
      errors++;
      $display("FAIL rst_rsp got v=%b id=%0d rd=%h busy=%b want all 0",
               rsp_valid, rsp_id, rsp_rdata, busy);
    end
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    bit   ok;
    bit   had;
    exp_t e;
    send(2, 1'b0, 16'h0010, 24'h0, ok);
    checks++;
    if (!ok || core_valid !== 1'b1 || core_addr !== 16'h0010 || core_write !== 1'b0) begin
      errors++;
      $display("FAIL t1_cmd ok=%b v=%b a=%h w=%b want ok=1 v=1 a=0010 w=0",
               ok, core_valid, core_addr, core_write);
    end
    wait_rsp(ok);
    pop_exp(e, had);
    checks++;
    if (!ok || !had || rsp_valid !== 4'b0100 || rsp_id !== e.id || rsp_rdata !== e.rdata) begin
      errors++;
      $display("FAIL t1_rsp v=%b id=%0d rd=%h want v=0100 id=%0d rd=%h",
               rsp_valid, rsp_id, rsp_rdata, e.id, e.rdata);
    end
    tick();
    checks++;
    if (rsp_valid !== '0 || rsp_id !== 2'd2 || rsp_rdata !== 24'hABCDEF) begin
      errors++;
      $display("FAIL t1_hold v=%b id=%0d rd=%h want v=0000 id=2 rd=abcdef",
               rsp_valid, rsp_id, rsp_rdata);
    end
  endtask

  task automatic test_round_robin();
    int   order[5] = '{0, 1, 2, 3, 0};
    int   gseq[$];
    int   got = 0;
    int   cyc = 0;
    int   start;
    int   g;
    bit   had;
    exp_t e;
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_write[i] = i[0];
      req_addr[i*AW +: AW] = 16'h0100 + AW'(i);
      req_wdata[i*DW +: DW] = 24'h100000 + DW'(i);
    end
    for (int k = 0; k < 5; k++)
      exp_q.push_back('{id: IW'(order[k]),
                        rdata: order[k][0] ? '0 : core_fn(16'h0100 + AW'(order[k]))});
    start = n_cmds;
    hot_err = 0;
    req_valid = '1;
    #1;
    while (got < 5 && cyc < 400) begin
      if (req_ready !== '0) begin
        g = 0;
        for (int b = 0; b < N; b++) if (req_ready[b]) g = b;
        gseq.push_back(g);
      end
      if (rsp_valid !== '0) begin
        pop_exp(e, had);
        checks++;
        if (!had || rsp_valid !== (4'b0001 << e.id) || rsp_id !== e.id || rsp_rdata !== e.rdata) begin
          errors++;
          $display("FAIL t2_rsp%0d v=%b id=%0d rd=%h want id=%0d rd=%h",
                   got, rsp_valid, rsp_id, rsp_rdata, e.id, e.rdata);
        end
        checks++;
        if (n_cmds - start !== got + 1) begin
          errors++;
          $display("FAIL t2_cmds%0d got=%0d want=%0d", got, n_cmds - start, got + 1);
        end
        got++;
        if (got == 5) req_valid = '0;
      end
      tick();
      cyc++;
    end
    checks++;
    if (got != 5 || gseq.size() != 5) begin
      errors++;
      $display("FAIL t2_count rsps=%0d grants=%0d want 5 and 5", got, gseq.size());
    end
    for (int k = 0; k < 5 && k < gseq.size(); k++) begin
      checks++;
      if (gseq[k] != order[k]) begin
        errors++;
        $display("FAIL t2_grant%0d got=%0d want=%0d", k, gseq[k], order[k]);
      end
    end
    checks++;
    if (hot_err != 0) begin
      errors++;
      $display("FAIL t2_onehot violations=%0d want 0", hot_err);
    end
  endtask

  task automatic test_write_stall();
    bit   ok;
    bit   had;
    exp_t e;
    int   n = 0;
    int   busy_bad = 0;
    int   cmd_bad = 0;
    int   vcyc = 0;
    lat = 6;
    hold_off = 5;
    send(1, 1'b1, 16'h00A0, 24'h123456, ok);
    while (rsp_valid === '0 && n < 100) begin
      if (busy !== 1'b1) busy_bad++;
      if (core_valid === 1'b1) begin
        vcyc++;
        if (core_addr !== 16'h00A0 || core_wdata !== 24'h123456 || core_write !== 1'b1)
          cmd_bad++;
      end
      tick();
      n++;
    end
    pop_exp(e, had);
    checks++;
    if (!ok || !had || rsp_valid !== 4'b0010 || rsp_id !== 2'd1 || rsp_rdata !== '0) begin
      errors++;
      $display("FAIL t3_rsp v=%b id=%0d rd=%h want v=0010 id=1 rd=000000",
               rsp_valid, rsp_id, rsp_rdata);
    end
    checks++;
    if (busy_bad != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t3_busy low_cycles=%0d busy=%b want 0 and 1", busy_bad, busy);
    end
    checks++;
    if (cmd_bad != 0 || vcyc != 6) begin
      errors++;
      $display("FAIL t3_cmd unstable=%0d valid_cycles=%0d want 0 and 6", cmd_bad, vcyc);
    end
    tick();
    lat = 3;
  endtask

  task automatic test_issue_stall();
    bit   ok;
    bit   had;
    exp_t e;
    int   n = 0;
    int   vcyc = 0;
    int   start;
    lat = 2;
    hold_off = 3;
    stab_err = 0;
    start = n_cmds;
    send(0, 1'b0, 16'h0033, 24'h0, ok);
    while (rsp_valid === '0 && n < 100) begin
      if (core_valid === 1'b1) vcyc++;
      tick();
      n++;
    end
    pop_exp(e, had);
    checks++;
    if (!ok || !had || rsp_valid !== 4'b0001 || rsp_id !== e.id || rsp_rdata !== e.rdata) begin
      errors++;
      $display("FAIL t4_rsp v=%b id=%0d rd=%h want v=0001 id=%0d rd=%h",
               rsp_valid, rsp_id, rsp_rdata, e.id, e.rdata);
    end
    checks++;
    if (vcyc != 4 || n_cmds - start != 1 || stab_err != 0) begin
      errors++;
      $display("FAIL t4_stall valid_cycles=%0d cmds=%0d unstable=%0d want 4 1 0",
               vcyc, n_cmds - start, stab_err);
    end
    tick();
    lat = 3;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int pulses = 0;
    lat = 8;
    send(3, 1'b0, 16'h0044, 24'h0, ok);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (!ok || {core_valid, core_write, core_addr, core_wdata, busy} !== '0) begin
      errors++;
      $display("FAIL t5_async_core ok=%b v=%b w=%b a=%h d=%h busy=%b want all 0",
               ok, core_valid, core_write, core_addr, core_wdata, busy);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_rdata, req_ready} !== '0) begin
      errors++;
      $display("FAIL t5_async_rsp v=%b id=%0d rd=%h rdy=%b want all 0",
               rsp_valid, rsp_id, rsp_rdata, req_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    lat = 3;
    for (int i = 0; i < 15; i++) begin
      if (rsp_valid !== '0) pulses++;
      tick();
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL t5_no_rsp pulses=%0d want 0", pulses);
    end
    req_valid[0] = 1'b1;
    req_valid[2] = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL t5_first_grant got=%b want=0001", req_ready);
    end
    req_valid = '0;
    tick();
    checks++;
    if (busy !== 1'b0 || core_valid !== 1'b0) begin
      errors++;
      $display("FAIL t5_withdraw busy=%b v=%b want 0 0", busy, core_valid);
    end
  endtask

`ifdef IRIS_ARB_LOCK_EN
  task automatic test_lock();
    bit   ok;
    bit   had;
    exp_t e;
    int   leak = 0;
    int   n = 0;
    do_reset();
    req_lock = '0;
    req_write[1] = 1'b0;
    req_addr[1*AW +: AW] = 16'h0066;
    req_valid[1] = 1'b1;
    req_lock[0] = 1'b1;
    send(0, 1'b0, 16'h0055, 24'h0, ok);
    wait_rsp(ok);
    pop_exp(e, had);
    checks++;
    if (!ok || !had || rsp_id !== 2'd0 || rsp_rdata !== e.rdata) begin
      errors++;
      $display("FAIL t6_lock_rsp id=%0d rd=%h want id=0 rd=%h", rsp_id, rsp_rdata, e.rdata);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (req_ready !== '0) leak++;
    end
    checks++;
    if (leak != 0) begin
      errors++;
      $display("FAIL t6_locked_out grants=%0d want 0", leak);
    end
    req_lock[0] = 1'b0;
    send(0, 1'b1, 16'h0055, 24'h00BEEF, ok);
    wait_rsp(ok);
    pop_exp(e, had);
    checks++;
    if (!ok || !had || rsp_valid !== 4'b0001 || rsp_rdata !== '0) begin
      errors++;
      $display("FAIL t6_unlock_rsp v=%b rd=%h want 0001 000000", rsp_valid, rsp_rdata);
    end
    while (req_ready[1] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL t6_req1_grant got=%b want=0010", req_ready);
    end
    exp_q.push_back('{id: 2'd1, rdata: core_fn(16'h0066)});
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(ok);
    pop_exp(e, had);
    checks++;
    if (!ok || !had || rsp_valid !== 4'b0010 || rsp_rdata !== e.rdata) begin
      errors++;
      $display("FAIL t6_req1_rsp v=%b rd=%h want 0010 %h", rsp_valid, rsp_rdata, e.rdata);
    end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_stall();
    test_issue_stall();
    test_reset_mid();
`ifdef IRIS_ARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
